// File: rtl/img_sram_pkg.sv
// Shared types for the image SRAM read/write paths: SRAM control bundle,
// transmit FSM states and the output FIFO payload.
package img_sram_pkg;

    localparam int unsigned IMG_DIM_W = 8;
    localparam int unsigned IMG_PIX_W = 8;
    localparam int unsigned IMG_CNT_W = IMG_DIM_W + 1;

    typedef struct packed {
        logic                 sense_en;
        logic                 write_en;
        logic [IMG_DIM_W-1:0] row;
        logic [IMG_DIM_W-1:0] col;
        logic [IMG_PIX_W-1:0] din;
    } img_sram_ctrl_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic                 last;
        logic [IMG_PIX_W-1:0] data;
    } tx_pix_t;

endpackage

// File: rtl/img_tx_fifo.sv
// Show-ahead synchronous FIFO for outgoing pixels (data + last flag).
// The head entry is visible on 'head' whenever 'count' is non-zero.
module img_tx_fifo
    import img_sram_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    push,
    input  tx_pix_t                 push_data,
    input  logic                    pop,
    output tx_pix_t                 head,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    tx_pix_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/io_tx_controller.sv
// Streams a stored frame out of the image SRAM row-major onto a valid/ready
// byte port, using a credit-limited FIFO to absorb read latency and backpressure.
module io_tx_controller
    import img_sram_pkg::*;
#(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned FDEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [IMG_DIM_W-1:0] nrows,
    input  logic [IMG_DIM_W-1:0] ncols,
    input  logic [IMG_PIX_W-1:0] sram_dout,
    output img_sram_ctrl_t       sram_ctrl,
    output logic [IMG_PIX_W-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 dout_last,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CW = $clog2(FDEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    tx_state_e              state;
    logic [IMG_CNT_W-1:0]   row_idx;
    logic [IMG_CNT_W-1:0]   col_idx;
    logic [IMG_CNT_W-1:0]   nrows_q;
    logic [IMG_CNT_W-1:0]   ncols_q;
    logic                   sense_q;
    logic [RD_LAT-1:0]      vld_pipe;
    logic [RD_LAT-1:0]      last_pipe;
    logic [CW-1:0]          fifo_count;
    tx_pix_t                fifo_head;
    tx_pix_t                push_data_c;
    logic [SW-1:0]          inflight_c;
    logic                   credit_ok_c;
    logic                   issue_c;
    logic                   last_col_c;
    logic                   last_addr_c;
    logic                   push_c;
    logic                   pop_c;
    logic                   drained_c;

    // Reads still travelling through the SRAM latency pipe.
    always_comb begin
        inflight_c = '0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            inflight_c = inflight_c + SW'(vld_pipe[i]);
        end
    end

    assign credit_ok_c = (SW'(fifo_count) + inflight_c) < SW'(FDEPTH);
    assign issue_c     = (state == RUN) && credit_ok_c;
    assign last_col_c  = (col_idx == (ncols_q - IMG_CNT_W'(1)));
    assign last_addr_c = last_col_c && (row_idx == nrows_q);
    assign push_c      = vld_pipe[RD_LAT-1];
    assign pop_c       = dout_valid && dout_ready;
    // Drain completes on the edge that pops the final byte, so done lands right after it.
    assign drained_c   = (inflight_c == '0) &&
                         ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop_c));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            row_idx <= '0;
            col_idx <= '0;
            nrows_q <= '0;
            ncols_q <= '0;
            sense_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        nrows_q <= IMG_CNT_W'(nrows);
                        ncols_q <= IMG_CNT_W'(ncols);
                        row_idx <= '0;
                        col_idx <= '0;
                        sense_q <= 1'b1;
                        if (ncols != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue_c) begin
                        if (last_addr_c) begin
                            state <= DRAIN;
                        end else if (last_col_c) begin
                            col_idx <= '0;
                            row_idx <= row_idx + IMG_CNT_W'(1);
                        end else begin
                            col_idx <= col_idx + IMG_CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drained_c) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    sense_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Issue flags ride alongside the SRAM read so data is captured as it emerges.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe[0]  <= issue_c;
            last_pipe[0] <= issue_c && last_addr_c;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    assign push_data_c.last = last_pipe[RD_LAT-1];
    assign push_data_c.data = sram_dout;

    img_tx_fifo #(
        .DEPTH (FDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push_c),
        .push_data (push_data_c),
        .pop       (pop_c),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign dout       = fifo_head.data;
    assign dout_valid = (fifo_count != '0);
    assign dout_last  = fifo_head.last && dout_valid;

    assign sram_ctrl.sense_en = sense_q;
    assign sram_ctrl.write_en = 1'b0;
    assign sram_ctrl.row      = row_idx[IMG_DIM_W-1:0];
    assign sram_ctrl.col      = col_idx[IMG_DIM_W-1:0];
    assign sram_ctrl.din      = '0;

endmodule

// File: tb/tb_io_tx_controller.sv
// Scoreboard bench: two controller instances (RD_LAT=1/FDEPTH=4 and
// RD_LAT=3/FDEPTH=8) share stimulus; each has its own SRAM model and monitor queue.
module tb_io_tx_controller;
    import img_sram_pkg::*;

    logic           clk;
    logic           rstn;
    logic           start;
    logic [7:0]     nrows;
    logic [7:0]     ncols;
    logic           dout_ready;

    img_sram_ctrl_t ctrl       [2];
    logic [7:0]     sram_dout  [2];
    logic [7:0]     dout       [2];
    logic           dout_valid [2];
    logic           dout_last  [2];
    logic           busy       [2];
    logic           done       [2];
    logic           ovf        [2];

    logic [7:0]     mem [0:65535];
    logic [8:0]     exp_q0 [$];
    logic [8:0]     exp_q1 [$];

    int             checks;
    int             failures;
    int             done_cnt [2];
    int             vcnt     [2];
    logic           held_v   [2];
    logic [7:0]     held_d   [2];
    logic           held_l   [2];
    logic           pend_done[2];
    int             mon_sz;
    logic [8:0]     mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int unsigned L = (g == 0) ? 1 : 3;
        localparam int unsigned D = (g == 0) ? 4 : 8;
        logic [7:0] dly [3];

        io_tx_controller #(
            .RD_LAT (L),
            .FDEPTH (D)
        ) u_dut (
            .clk        (clk),
            .rstn       (rstn),
            .start      (start),
            .nrows      (nrows),
            .ncols      (ncols),
            .sram_dout  (sram_dout[g]),
            .sram_ctrl  (ctrl[g]),
            .dout       (dout[g]),
            .dout_valid (dout_valid[g]),
            .dout_ready (dout_ready),
            .dout_last  (dout_last[g]),
            .busy       (busy[g]),
            .done       (done[g])
        );

        // SRAM with L-cycle read latency.
        always @(posedge clk) begin
            dly[0] <= mem[{ctrl[g].row, ctrl[g].col}];
            dly[1] <= dly[0];
            dly[2] <= dly[1];
        end
        assign sram_dout[g] = dly[L-1];
        assign ovf[g] = u_dut.push_c && (32'(u_dut.fifo_count) == D) &&
                        !(dout_valid[g] && dout_ready);
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int dep_of(input int k);
        return (k == 0) ? 4 : 8;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s lane%0d actual=%0h required=%0h", name, k, act, req);
        end
    endtask

    // Monitor: pops the lane's queue on every transfer and checks hold/done behaviour.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rstn) begin
                held_v[k]    = 1'b0;
                pend_done[k] = 1'b0;
            end else begin
                chk("write_en", k, 32'(ctrl[k].write_en), 32'(0));
                chk("fifo_overflow", k, 32'(ovf[k]), 32'(0));
                if (held_v[k]) begin
                    chk("hold_valid", k, 32'(dout_valid[k]), 32'(1));
                    chk("hold_data", k, 32'(dout[k]), 32'(held_d[k]));
                    chk("hold_last", k, 32'(dout_last[k]), 32'(held_l[k]));
                end
                if (pend_done[k]) chk("done_after_last", k, 32'(done[k]), 32'(1));
                pend_done[k] = 1'b0;
                held_v[k]    = 1'b0;
                if (done[k]) done_cnt[k]++;
                if (dout_valid[k]) begin
                    vcnt[k]++;
                    if (dout_ready) begin
                        mon_sz = (k == 0) ? exp_q0.size() : exp_q1.size();
                        chk("pixel_expected", k, 32'(mon_sz != 0), 32'(1));
                        if (mon_sz != 0) begin
                            mon_e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                            chk("pixel_data", k, 32'(dout[k]), 32'(mon_e[7:0]));
                            chk("pixel_last", k, 32'(dout_last[k]), 32'(mon_e[8]));
                            pend_done[k] = mon_e[8];
                        end
                    end else begin
                        held_v[k] = 1'b1;
                        held_d[k] = dout[k];
                        held_l[k] = dout_last[k];
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int nr, input int nc);
        logic [8:0] e;
        for (int r = 0; r <= nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                e = {1'((r == nr) && (c == nc - 1)), mem[r*256 + c]};
                exp_q0.push_back(e);
                exp_q1.push_back(e);
            end
        end
    endtask

    task automatic new_frame();
        for (int k = 0; k < 2; k++) begin
            done_cnt[k] = 0;
            vcnt[k]     = 0;
        end
    endtask

    task automatic pulse_start(input int nr, input int nc);
        nrows = 8'(nr);
        ncols = 8'(nc);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_frame(input int budget, input bit toggle);
        int n;
        n = 0;
        while (!(done_cnt[0] >= 1 && done_cnt[1] >= 1 && !busy[0] && !busy[1]) && n < budget) begin
            if (toggle) dout_ready = ~dout_ready;
            tick();
            n++;
        end
        chk("frame_in_budget", 0, 32'(n < budget), 32'(1));
        dout_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic end_frame();
        for (int k = 0; k < 2; k++) begin
            chk("done_pulses", k, 32'(done_cnt[k]), 32'(1));
            chk("bytes_left", k, 32'((k == 0) ? exp_q0.size() : exp_q1.size()), 32'(0));
            chk("busy_after", k, 32'(busy[k]), 32'(0));
            chk("valid_after", k, 32'(dout_valid[k]), 32'(0));
        end
    endtask

    task automatic check_reset_vals();
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy", k, 32'(busy[k]), 32'(0));
            chk("rst_done", k, 32'(done[k]), 32'(0));
            chk("rst_valid", k, 32'(dout_valid[k]), 32'(0));
            chk("rst_last", k, 32'(dout_last[k]), 32'(0));
            chk("rst_dout", k, 32'(dout[k]), 32'(0));
            chk("rst_sense", k, 32'(ctrl[k].sense_en), 32'(0));
            chk("rst_row", k, 32'(ctrl[k].row), 32'(0));
            chk("rst_col", k, 32'(ctrl[k].col), 32'(0));
            chk("rst_din", k, 32'(ctrl[k].din), 32'(0));
        end
    endtask

    initial begin
        int xfers;
        int lin;
        int lt;
        checks     = 0;
        failures   = 0;
        rstn       = 1'b0;
        start      = 1'b0;
        nrows      = '0;
        ncols      = '0;
        dout_ready = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'((i >> 8) * 31 + (i & 255) * 7 + 5);
        for (int i = 0; i < 3; i++) begin
            mem[i]       = 8'(8'h10 + i);
            mem[256 + i] = 8'(8'h13 + i);
        end
        new_frame();
        repeat (3) tick();
        check_reset_vals();
        rstn = 1'b1;
        tick();

        // 2x3 frame, ready=1: exact cycle timing of valid, done and busy.
        new_frame();
        push_frame(1, 3);
        pulse_start(1, 3);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                lt = lat_of(k);
                chk("seq_valid", k, 32'(dout_valid[k]), 32'((cyc >= 1 + lt) && (cyc <= 6 + lt)));
                chk("seq_done", k, 32'(done[k]), 32'(cyc == 7 + lt));
                chk("seq_busy", k, 32'(busy[k]), 32'(cyc < 7 + lt));
            end
        end
        wait_frame(200, 1'b0);
        end_frame();

        // Same frame with ready toggling every cycle.
        new_frame();
        push_frame(1, 3);
        pulse_start(1, 3);
        wait_frame(200, 1'b1);
        end_frame();

        // Ready held low mid-frame: issues stop once all credits are outstanding.
        new_frame();
        push_frame(3, 8);
        pulse_start(3, 8);
        repeat (6) tick();
        dout_ready = 1'b0;
        repeat (20) tick();
        for (int k = 0; k < 2; k++) begin
            xfers = 32 - ((k == 0) ? exp_q0.size() : exp_q1.size());
            lin   = int'(ctrl[k].row) * 8 + int'(ctrl[k].col);
            chk("issued_under_hold", k, 32'(lin), 32'(xfers + dep_of(k)));
            chk("valid_under_hold", k, 32'(dout_valid[k]), 32'(1));
        end
        dout_ready = 1'b1;
        wait_frame(300, 1'b0);
        end_frame();

        // start re-pulsed mid-frame with other geometry is ignored.
        new_frame();
        push_frame(1, 3);
        pulse_start(1, 3);
        tick();
        tick();
        pulse_start(5, 9);
        wait_frame(200, 1'b0);
        end_frame();

        // ncols=0: done pulse only, no pixels.
        new_frame();
        pulse_start(4, 0);
        wait_frame(50, 1'b0);
        end_frame();
        for (int k = 0; k < 2; k++) chk("zero_col_no_valid", k, 32'(vcnt[k]), 32'(0));

        // Asynchronous reset mid-frame, then a clean frame from (0,0).
        new_frame();
        push_frame(3, 8);
        pulse_start(3, 8);
        repeat (5) tick();
        #2;
        rstn = 1'b0;
        #1;
        check_reset_vals();
        exp_q0.delete();
        exp_q1.delete();
        tick();
        tick();
        for (int k = 0; k < 2; k++) chk("rst_no_done", k, 32'(done_cnt[k]), 32'(0));
        rstn = 1'b1;
        tick();
        new_frame();
        push_frame(1, 3);
        pulse_start(1, 3);
        wait_frame(200, 1'b0);
        end_frame();

        // Largest frame: 256 rows x 255 cols.
        new_frame();
        push_frame(255, 255);
        pulse_start(255, 255);
        wait_frame(70000, 1'b0);
        end_frame();
        for (int k = 0; k < 2; k++) begin
            chk("big_last_row", k, 32'(ctrl[k].row), 32'(255));
            chk("big_last_col", k, 32'(ctrl[k].col), 32'(254));
            chk("big_byte_count", k, 32'(vcnt[k]), 32'(65280));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
